// File: rtl/layer_input_sequencer_if.sv
// Handshake bundle between the network controller, the layer sequencer and the
// layer's MAC/ack-counter pair.
interface layer_input_sequencer_if #(
    parameter int N_INPUTS  = 3,
    parameter int N_NEURONS = 4,
    parameter int DATA_W    = 8
);
    localparam int IDX_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
    localparam int NRN_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                         start;
    logic                         stall;
    logic [N_INPUTS*DATA_W-1:0]   in_vec;
    logic                         ack__mac;
    logic [DATA_W-1:0]            mac_x;
    logic [IDX_W-1:0]             mac_idx;
    logic                         ack;
    logic                         cnt_rst;
    logic [NRN_W-1:0]             neuron_idx;
    logic                         busy;
    logic                         done;
    logic                         err;

    // Controller / environment side.
    modport master (
        output start, stall, in_vec, ack__mac,
        input  mac_x, mac_idx, ack, cnt_rst, neuron_idx, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, stall, in_vec, ack__mac,
        output mac_x, mac_idx, ack, cnt_rst, neuron_idx, busy, done, err
    );
endinterface

// File: rtl/layer_input_sequencer.sv
// Walks every neuron of a layer: clears the ack counter, streams the input
// vector word by word, then waits for the counter's completion flag.
module layer_input_sequencer #(
    parameter int N_INPUTS  = 3,
    parameter int N_NEURONS = 4,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 15
) (
    input logic                    clk,
    input logic                    rst,
    layer_input_sequencer_if.slave bus
);
    localparam int IDX_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
    localparam int NRN_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_INPUTS - 1);
    localparam logic [NRN_W-1:0] LAST_NRN  = NRN_W'(N_NEURONS - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   mac_idx_q, mac_idx_d;
    logic [NRN_W-1:0]   neuron_idx_q, neuron_idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  mac_x_q, mac_x_d;
    logic               cnt_rst_q, busy_q, done_q;

    logic [DATA_W-1:0]  words [N_INPUTS];
    logic [DATA_W-1:0]  word_sel;

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_words
            assign words[gi] = bus.in_vec[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (mac_idx_d == IDX_W'(i)) begin
                word_sel = words[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mac_idx_d    = mac_idx_q;
        neuron_idx_d = neuron_idx_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        mac_x_d      = mac_x_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_CLEAR;
                    neuron_idx_d = '0;
                    err_d        = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d   = S_FEED;
                mac_idx_d = '0;
            end
            S_FEED: begin
                if (!bus.stall) begin
                    if (mac_idx_q == LAST_IDX) begin
                        state_d = S_WAIT;
                        tmo_d   = '0;
                    end else begin
                        mac_idx_d = mac_idx_q + IDX_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (bus.ack__mac) begin
                    state_d = S_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_NEXT: begin
                if (neuron_idx_q == LAST_NRN) begin
                    state_d = S_DONE;
                end else begin
                    neuron_idx_d = neuron_idx_q + NRN_W'(1);
                    state_d      = S_CLEAR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // mac_x tracks the word the MAC will see in the coming FEED cycle.
        if (state_d == S_FEED) begin
            mac_x_d = word_sel;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mac_idx_q    <= '0;
            neuron_idx_q <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            mac_x_q      <= '0;
            cnt_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mac_idx_q    <= mac_idx_d;
            neuron_idx_q <= neuron_idx_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            mac_x_q      <= mac_x_d;
            cnt_rst_q    <= (state_d == S_CLEAR);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
        end
    end

    // The strobe gates the registered FEED state with the live stall so each
    // pulse coincides with exactly the edge that advances mac_idx.
    assign bus.ack        = (state_q == S_FEED) && !bus.stall;
    assign bus.mac_x      = mac_x_q;
    assign bus.mac_idx    = mac_idx_q;
    assign bus.cnt_rst    = cnt_rst_q;
    assign bus.neuron_idx = neuron_idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_layer_input_sequencer.sv
// Bench for the layer input sequencer with an attached ack-counter model and
// a scoreboard of expected (neuron, index, word) strobes.
module tb_layer_input_sequencer;
    localparam int N_INPUTS  = 3;
    localparam int N_NEURONS = 2;
    localparam int DATA_W    = 8;
    localparam int TIMEOUT   = 15;
    localparam int IDX_W     = 2;
    localparam int NRN_W     = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer_input_sequencer_if #(.N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS), .DATA_W(DATA_W)) bus ();

    layer_input_sequencer #(
        .N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NRN_W-1:0]  nrn;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] word;
    } exp_t;
    exp_t sb[$];

    // Counter model: counts strobes after a clear, sticky flag at terminal count.
    int   cnt_model;
    logic flag_model;
    int   flag_mode = 0;  // 0 = counter model, 1 = tied low, 2 = stuck high
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_model  <= 0;
            flag_model <= 1'b0;
        end else if (bus.cnt_rst) begin
            cnt_model  <= 0;
            flag_model <= 1'b0;
        end else if (bus.ack) begin
            cnt_model <= cnt_model + 1;
            if (cnt_model == N_INPUTS - 1) flag_model <= 1'b1;
        end
    end
    assign bus.ack__mac = (flag_mode == 2) ? 1'b1 : (flag_mode == 1) ? 1'b0 : flag_model;

    int ack_cnt, crst_cnt, done_cnt, busy_cycles;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (bus.ack) begin
                    ack_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: unexpected ack mac_x=%0h idx=%0d nrn=%0d",
                                 bus.mac_x, bus.mac_idx, bus.neuron_idx);
                    end else begin
                        e = sb.pop_front();
                        if (bus.mac_x !== e.word || bus.mac_idx !== e.idx || bus.neuron_idx !== e.nrn) begin
                            errors++;
                            $display("FAIL ack_word: got nrn=%0d idx=%0d x=%0h expected nrn=%0d idx=%0d x=%0h",
                                     bus.neuron_idx, bus.mac_idx, bus.mac_x, e.nrn, e.idx, e.word);
                        end else begin
                            $display("ack nrn=%0d idx=%0d x=%0h", bus.neuron_idx, bus.mac_idx, bus.mac_x);
                        end
                    end
                end
                if (bus.busy) begin
                    checks++;
                    if (bus.ack === 1'b1 && bus.cnt_rst === 1'b1) begin
                        errors++;
                        $display("FAIL ack_cnt_rst_overlap: got both high expected exclusive");
                    end
                end
                if (bus.cnt_rst) crst_cnt++;
                if (bus.done)    done_cnt++;
                if (bus.busy)    busy_cycles++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        ack_cnt = 0; crst_cnt = 0; done_cnt = 0; busy_cycles = 0;
    endtask

    task automatic start_pass(input logic [N_INPUTS*DATA_W-1:0] vec, input int n_nrn);
        exp_t e;
        for (int n = 0; n < n_nrn; n++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                e.nrn  = NRN_W'(n);
                e.idx  = IDX_W'(i);
                e.word = vec[i*DATA_W +: DATA_W];
                sb.push_back(e);
            end
        end
        @(negedge clk); #1;
        bus.in_vec = vec;
        bus.start  = 1'b1;
        @(negedge clk); #1;
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge clk);
            if (bus.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done within 300 cycles", name);
        end
        @(negedge clk); #1;
    endtask

    task automatic check_pass(input string name, input int exp_ack, input int exp_crst,
                              input int exp_busy, input logic exp_err);
        checks++;
        if (ack_cnt !== exp_ack) begin
            errors++; $display("FAIL %s_ack_count: got %0d expected %0d", name, ack_cnt, exp_ack);
        end
        checks++;
        if (crst_cnt !== exp_crst) begin
            errors++; $display("FAIL %s_cnt_rst_count: got %0d expected %0d", name, crst_cnt, exp_crst);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (busy_cycles !== exp_busy) begin
            errors++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cycles, exp_busy);
        end
        checks++;
        if (bus.err !== exp_err) begin
            errors++; $display("FAIL %s_err: got %0b expected %0b", name, bus.err, exp_err);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL %s_sb_left: got %0d pending expected 0", name, sb.size());
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s_idle_busy: got %0b expected 0", name, bus.busy);
        end
        $display("pass %s: acks=%0d cnt_rst=%0d done=%0d busy=%0d err=%0b",
                 name, ack_cnt, crst_cnt, done_cnt, busy_cycles, bus.err);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.ack !== 1'b0 || bus.cnt_rst !== 1'b0 || bus.done !== 1'b0 ||
            bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: got ack=%0b cnt_rst=%0b done=%0b busy=%0b err=%0b expected all 0",
                     name, bus.ack, bus.cnt_rst, bus.done, bus.busy, bus.err);
        end
        checks++;
        if (bus.mac_x !== '0 || bus.mac_idx !== '0 || bus.neuron_idx !== '0) begin
            errors++;
            $display("FAIL %s_values: got mac_x=%0h mac_idx=%0d neuron_idx=%0d expected 0",
                     name, bus.mac_x, bus.mac_idx, bus.neuron_idx);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset_idle");
    endtask

    task automatic test_basic();
        flag_mode = 0;
        clear_stats();
        start_pass(24'h030201, N_NEURONS);
        checks++;
        if (bus.cnt_rst !== 1'b1 || bus.ack !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_clear_cycle: got cnt_rst=%0b ack=%0b busy=%0b expected 1 0 1",
                     bus.cnt_rst, bus.ack, bus.busy);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ack !== 1'b1 || bus.mac_x !== 8'h01 || bus.cnt_rst !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_ack: got ack=%0b mac_x=%0h cnt_rst=%0b expected 1 01 0",
                     bus.ack, bus.mac_x, bus.cnt_rst);
        end
        wait_done("basic");
        check_pass("basic", 6, 2, 13, 1'b0);
    endtask

    task automatic test_stall();
        bit found = 0;
        flag_mode = 0;
        clear_stats();
        start_pass(24'hC3B2A1, N_NEURONS);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk); #1;
            if (bus.ack === 1'b1 && bus.mac_idx === IDX_W'(1)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL stall_reach_idx1: got not reached expected mac_idx=1 in FEED");
        end else begin
            bus.stall = 1'b1;
            #1;
            checks++;
            if (bus.ack !== 1'b0 || bus.mac_x !== 8'hB2) begin
                errors++; $display("FAIL stall_cycle1: got ack=%0b mac_x=%0h expected 0 b2", bus.ack, bus.mac_x);
            end
            @(negedge clk); #1;
            checks++;
            if (bus.ack !== 1'b0 || bus.mac_x !== 8'hB2 || bus.mac_idx !== IDX_W'(1)) begin
                errors++;
                $display("FAIL stall_cycle2: got ack=%0b mac_x=%0h idx=%0d expected 0 b2 1",
                         bus.ack, bus.mac_x, bus.mac_idx);
            end
            @(negedge clk); #1;
            bus.stall = 1'b0;
            #1;
            checks++;
            if (bus.ack !== 1'b1 || bus.mac_x !== 8'hB2) begin
                errors++; $display("FAIL stall_release: got ack=%0b mac_x=%0h expected 1 b2", bus.ack, bus.mac_x);
            end
        end
        wait_done("stall");
        check_pass("stall", 6, 2, 15, 1'b0);
    endtask

    task automatic test_timeout();
        flag_mode = 1;
        clear_stats();
        start_pass(24'h554433, 1);
        wait_done("timeout");
        check_pass("timeout", 3, 1, 20, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL timeout_err_sticky: got %0b expected 1", bus.err);
        end
        flag_mode = 0;
        clear_stats();
        start_pass(24'h030201, N_NEURONS);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL timeout_err_clear: got %0b expected 0", bus.err);
        end
        wait_done("after_timeout");
        check_pass("after_timeout", 6, 2, 13, 1'b0);
    endtask

    task automatic test_stuck_flag();
        flag_mode = 2;
        clear_stats();
        start_pass(24'h0F0E0D, N_NEURONS);
        wait_done("stuck_flag");
        check_pass("stuck_flag", 6, 2, 13, 1'b0);
        flag_mode = 0;
    endtask

    task automatic test_back_to_back();
        flag_mode = 0;
        clear_stats();
        start_pass(24'h9A7856, N_NEURONS);
        bus.start = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("busy_start");
        check_pass("busy_start", 6, 2, 13, 1'b0);
    endtask

    task automatic test_reset_abort();
        bit found = 0;
        flag_mode = 0;
        clear_stats();
        start_pass(24'h332211, N_NEURONS);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk); #1;
            if (bus.ack === 1'b1 && bus.mac_idx === IDX_W'(1)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL abort_reach_feed: got not reached expected FEED with mac_idx=1");
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt);
        end
        clear_stats();
        start_pass(24'h665544, N_NEURONS);
        wait_done("after_abort");
        check_pass("after_abort", 6, 2, 13, 1'b0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.stall  = 1'b0;
        bus.in_vec = '0;
        clear_stats();
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_stuck_flag();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
